// File: rtl/cpu_control_unit.sv
// Multi-cycle accumulator CPU control unit: fetch/decode/execute FSM driving an external RAM and ALU.
// Optional opcode 4 (Subtract) is enabled by defining CPU_CTRL_SUBT_EN.
module cpu_control_unit #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 16,
    parameter int unsigned START_ADDR = 'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  busy,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out
);

`ifdef CPU_CTRL_SUBT_EN
    localparam bit SUBT_EN = 1'b1;
`else
    localparam bit SUBT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    typedef enum logic [3:0] {
        IDLE, F_ADDR, F_READ, DECODE, E_ADDR, E_READ, E_ALU, E_WB, E_STORE, HALT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] mbr;
    logic [DATA_WIDTH-1:0] ac;
    logic                  cs_q;
    logic                  we_q;
    logic                  oe_q;
    logic [1:0]            alu_sel_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand_addr;
    logic                  is_arith;
    logic                  ac_neg;
    logic                  ac_zero;
    logic                  skip_cond;

    assign opcode       = ir[DATA_WIDTH-1 -: 4];
    assign operand_addr = ADDR_WIDTH'(ir[11:0]);
    assign is_arith     = (opcode == OP_ADD) || (SUBT_EN && (opcode == OP_SUBT));
    assign ac_neg       = ac[DATA_WIDTH-1];
    assign ac_zero      = (ac == '0);

    always_comb begin
        skip_cond = 1'b0;
        case (ir[11:10])
            2'b00:   skip_cond = ac_neg;
            2'b01:   skip_cond = ac_zero;
            2'b10:   skip_cond = !ac_neg && !ac_zero;
            default: skip_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            mbr       <= '0;
            ac        <= '0;
            mem_addr  <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            alu_sel_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            wdata_q   <= '0;
        end else begin
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            alu_sel_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            wdata_q   <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= ADDR_WIDTH'(START_ADDR);
                        state <= F_ADDR;
                    end
                end
                F_ADDR: begin
                    mem_addr <= pc;
                    cs_q     <= 1'b1;
                    oe_q     <= 1'b1;
                    state    <= F_READ;
                end
                F_READ: begin
                    ir    <= mem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    pc <= pc + ADDR_WIDTH'(1);
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_ADD:  state <= E_ADDR;
                        OP_SUBT:                    state <= SUBT_EN ? E_ADDR : F_ADDR;
                        OP_SKIP, OP_JUMP, OP_CLEAR: state <= E_WB;
                        OP_HALT:                    state <= HALT;
                        default:                    state <= F_ADDR;
                    endcase
                end
                E_ADDR: begin
                    mem_addr <= operand_addr;
                    cs_q     <= 1'b1;
                    if (opcode == OP_STORE) begin
                        mbr     <= ac;
                        wdata_q <= ac;
                        we_q    <= 1'b1;
                        state   <= E_STORE;
                    end else begin
                        oe_q  <= 1'b1;
                        state <= E_READ;
                    end
                end
                E_READ: begin
                    mbr <= mem_rdata;
                    if (is_arith) begin
                        alu_a_q   <= ac;
                        alu_b_q   <= mem_rdata;
                        alu_sel_q <= (opcode == OP_SUBT) ? 2'b10 : 2'b01;
                        state     <= E_ALU;
                    end else begin
                        state <= E_WB;
                    end
                end
                E_ALU: begin
                    // Result parked in MBR: alu_sel returns to 00 in E_WB, so alu_out is no longer valid there.
                    mbr   <= alu_out;
                    state <= E_WB;
                end
                E_WB: begin
                    case (opcode)
                        OP_LOAD, OP_ADD, OP_SUBT: ac <= mbr;
                        OP_SKIP:  if (skip_cond) pc <= pc + ADDR_WIDTH'(1);
                        OP_JUMP:  pc <= operand_addr;
                        OP_CLEAR: ac <= '0;
                        default:  ;
                    endcase
                    state <= F_ADDR;
                end
                E_STORE: state <= F_ADDR;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes are masked by rst so a store caught mid-cycle by reset never commits.
    assign mem_cs    = cs_q && !rst;
    assign mem_we    = we_q && !rst;
    assign mem_oe    = oe_q && !rst;
    assign mem_wdata = rst ? '0 : wdata_q;
    assign alu_a     = rst ? '0 : alu_a_q;
    assign alu_b     = rst ? '0 : alu_b_q;
    assign alu_sel   = rst ? '0 : alu_sel_q;
    assign busy      = !rst && (state != IDLE) && (state != HALT);
    assign halted    = !rst && (state == HALT);
    assign pc_out    = pc;
    assign ac_out    = ac;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: RAM/ALU models, directed programs, monitor checks bus events.
module tb_cpu_control_unit;

    localparam int AW = 14;
    localparam int DW = 16;

    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_ST   = 2'd1;
    localparam logic [1:0] K_HALT = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_sel;
    logic [DW-1:0] alu_out;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ac_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    ev_t           exp_q[$];
    int            vectors;
    int            errors;

    cpu_control_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .START_ADDR('h100)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .halted(halted), .pc_out(pc_out), .ac_out(ac_out)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_cs && mem_oe) ? mem[mem_addr] : '0;
    assign alu_out   = (alu_sel == 2'b01) ? alu_a + alu_b :
                       (alu_sel == 2'b10) ? alu_a - alu_b : '0;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic string kname(input logic [1:0] k);
        case (k)
            K_RD:    return "read";
            K_ST:    return "store";
            K_HALT:  return "halt";
            default: return "unknown";
        endcase
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic void exp_rd(input logic [AW-1:0] a);
        exp_q.push_back({K_RD, a, 16'h0000});
    endfunction

    function automatic void exp_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({K_ST, a, d});
    endfunction

    function automatic void exp_halt(input logic [AW-1:0] pc, input logic [DW-1:0] ac);
        exp_q.push_back({K_HALT, pc, ac});
    endfunction

    // Monitor: one event per negedge where the DUT presents a store, a read, or a halt.
    initial begin : monitor
        ev_t  got;
        ev_t  want;
        logic have;
        logic prev_h;
        prev_h = 1'b0;
        forever begin
            @(negedge clk);
            have = 1'b0;
            got  = '0;
            if (mem_we && mem_oe) begin
                vectors++;
                errors++;
                $display("FAIL we_oe_exclusive: mem_we=%b mem_oe=%b, required not both 1", mem_we, mem_oe);
            end
            if (!rst) begin
                if (mem_cs && mem_we) begin
                    got = {K_ST, mem_addr, mem_wdata}; have = 1'b1;
                end else if (mem_cs && mem_oe) begin
                    got = {K_RD, mem_addr, 16'h0000}; have = 1'b1;
                end else if (halted && !prev_h) begin
                    got = {K_HALT, pc_out, ac_out}; have = 1'b1;
                end
            end
            prev_h = halted;
            if (have) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_%s: got addr=%h data=%h, required no event",
                             kname(got.kind), got.addr, got.data);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL %s: got %s addr=%h data=%h, required %s addr=%h data=%h",
                                 kname(want.kind), kname(got.kind), got.addr, got.data,
                                 kname(want.kind), want.addr, want.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 'h100; i < 'h110; i++) mem[i] = '0;
    endtask

    task automatic run(input string name, input int exp_cycles, input int extra_start);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == extra_start);
        end
        start = 1'b0;
        chk({name, "_cycles"}, 64'(n), 64'(exp_cycles));
        @(negedge clk);
        @(negedge clk);
        chk({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        int n;
        clk     = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        vectors = 0;
        errors  = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({mem_cs, mem_we, mem_oe, busy, halted, alu_sel, alu_a, alu_b, mem_wdata}), 64'd0);
        chk("reset_regs", 64'({mem_addr, pc_out, ac_out}), 64'd0);

        // rst wins over start in the same cycle
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_over_start_busy", 64'(busy), 64'd0);

        // Load 7, add 5, store 12, halt
        do_reset();
        mem['h100] = 16'h110C; mem['h101] = 16'h310B; mem['h102] = 16'h210D; mem['h103] = 16'h7000;
        mem['h10B] = 16'h0005; mem['h10C] = 16'h0007;
        exp_rd('h100); exp_rd('h10C); exp_rd('h101); exp_rd('h10B); exp_rd('h102);
        exp_st('h10D, 16'h000C); exp_rd('h103); exp_halt('h104, 16'h000C);
        run("prog_add", 21, -1);
        chk("prog_add_mem10d", 64'(mem['h10D]), 64'h000C);
        chk("prog_add_busy_in_halt", 64'(busy), 64'd0);

        // Same program with a stray start pulse mid-run
        do_reset();
        mem['h100] = 16'h110C; mem['h101] = 16'h310B; mem['h102] = 16'h210D; mem['h103] = 16'h7000;
        mem['h10B] = 16'h0005; mem['h10C] = 16'h0007;
        exp_rd('h100); exp_rd('h10C); exp_rd('h101); exp_rd('h10B); exp_rd('h102);
        exp_st('h10D, 16'h000C); exp_rd('h103); exp_halt('h104, 16'h000C);
        run("start_busy", 21, 5);

        // AC==0 skip taken: 9105 at 102 is skipped
        do_reset();
        mem['h100] = 16'hA000; mem['h101] = 16'h8400; mem['h102] = 16'h9105; mem['h103] = 16'h7000;
        mem['h105] = 16'h210D;
        exp_rd('h100); exp_rd('h101); exp_rd('h103); exp_halt('h104, 16'h0000);
        run("skip_zero", 11, -1);

        // AC=5: no skip, jump to 105 taken
        do_reset();
        mem['h100] = 16'h110B; mem['h101] = 16'h8400; mem['h102] = 16'h9105; mem['h103] = 16'h210D;
        mem['h104] = 16'h7000; mem['h105] = 16'h7000; mem['h10B] = 16'h0005;
        exp_rd('h100); exp_rd('h10B); exp_rd('h101); exp_rd('h102); exp_rd('h105);
        exp_halt('h106, 16'h0005);
        run("jump_taken", 17, -1);

        // Negative AC: 8000 skips, 8800 and 8C00 do not
        do_reset();
        mem['h100] = 16'h110E; mem['h101] = 16'h8000; mem['h102] = 16'h7000; mem['h103] = 16'h8800;
        mem['h104] = 16'h8C00; mem['h105] = 16'h7000; mem['h10E] = 16'h8000;
        exp_rd('h100); exp_rd('h10E); exp_rd('h101); exp_rd('h103); exp_rd('h104); exp_rd('h105);
        exp_halt('h106, 16'h8000);
        run("skip_neg", 21, -1);

        // Jump 9102: next fetch at 102
        do_reset();
        mem['h100] = 16'h9102; mem['h101] = 16'h210D; mem['h102] = 16'h7000;
        exp_rd('h100); exp_rd('h102); exp_halt('h103, 16'h0000);
        run("jump_102", 7, -1);

        // Opcode 4: subtract when enabled, NOP otherwise
        do_reset();
        mem['h100] = 16'h110C; mem['h101] = 16'h410B; mem['h102] = 16'h7000;
        mem['h10B] = 16'h0005; mem['h10C] = 16'h0007;
        exp_rd('h100); exp_rd('h10C); exp_rd('h101);
`ifdef CPU_CTRL_SUBT_EN
        exp_rd('h10B); exp_rd('h102); exp_halt('h103, 16'h0002);
        run("subt", 16, -1);
`else
        exp_rd('h102); exp_halt('h103, 16'h0007);
        run("subt_nop", 12, -1);
`endif

        // Reset landing in E_STORE must not commit the write
        do_reset();
        mem['h100] = 16'h110C; mem['h101] = 16'h210D; mem['h10C] = 16'h0007; mem['h10D] = 16'hABCD;
        exp_rd('h100); exp_rd('h10C); exp_rd('h101); exp_st('h10D, 16'h0007);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("store_reaches_estore", 64'(n), 64'd10);
        #1 rst = 1'b1;
        #1 chk("rst_estore_we_now", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_estore_mem10d", 64'(mem['h10D]), 64'hABCD);
        chk("rst_estore_outputs",
            64'({mem_cs, mem_we, mem_oe, busy, halted, alu_sel, alu_a, alu_b, mem_wdata}), 64'd0);
        chk("rst_estore_regs", 64'({mem_addr, pc_out, ac_out}), 64'd0);
        @(negedge clk);
        chk("rst_estore_events_left", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
